// File: rtl/gpu_mem_pkg.sv
// Shared types for the global data-memory port arbiter.
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        RESPOND
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: first requesting channel after i_last_grant, wrapping modulo CHANNELS.
module rr_picker #(
    parameter int CHANNELS = 4,
    parameter int IDX_BITS = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [IDX_BITS-1:0] i_last_grant,
    output logic                o_found,
    output logic [IDX_BITS-1:0] o_idx
);

    logic [IDX_BITS-1:0] w_cand;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        // Walk from the farthest offset down so the nearest requester overwrites the rest.
        for (int off = CHANNELS; off >= 1; off--) begin
            w_cand = IDX_BITS'((int'(i_last_grant) + off) % CHANNELS);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one global data-memory port between CHANNELS requesters;
// a grant is held for one complete read or write transaction.
module mem_port_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int CHANNELS  = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,

    input  logic [CHANNELS-1:0]                  req_read_valid,
    input  logic [CHANNELS-1:0][ADDR_BITS-1:0]   req_read_address,
    output logic [CHANNELS-1:0]                  req_read_ready,
    output logic [CHANNELS-1:0][DATA_BITS-1:0]   req_read_data,

    input  logic [CHANNELS-1:0]                  req_write_valid,
    input  logic [CHANNELS-1:0][ADDR_BITS-1:0]   req_write_address,
    input  logic [CHANNELS-1:0][DATA_BITS-1:0]   req_write_data,
    output logic [CHANNELS-1:0]                  req_write_ready,

    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,

    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready,

    output logic [$clog2(CHANNELS)-1:0]          grant,
    output logic                                 busy
);

    localparam int GW = $clog2(CHANNELS);

    arb_state_t           r_state;
    logic [GW-1:0]        r_grant;
    logic [GW-1:0]        r_last_grant;
    logic [ADDR_BITS-1:0] r_addr_q;
    logic [DATA_BITS-1:0] r_wdata_q;
    logic [DATA_BITS-1:0] r_rdata_q;
    logic                 r_is_read_q;
    logic                 r_mem_rd_valid;
    logic                 r_mem_wr_valid;
    logic                 r_resp_ready;

    logic [CHANNELS-1:0]  w_req;
    logic                 w_found;
    logic [GW-1:0]        w_idx;
    logic                 w_granted_valid;

    assign w_req           = req_read_valid | req_write_valid;
    assign w_granted_valid = r_is_read_q ? req_read_valid[r_grant] : req_write_valid[r_grant];

    rr_picker #(
        .CHANNELS (CHANNELS),
        .IDX_BITS (GW)
    ) u_picker (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_found      (w_found),
        .o_idx        (w_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_grant        <= '0;
            r_last_grant   <= GW'(CHANNELS - 1);
            r_addr_q       <= '0;
            r_wdata_q      <= '0;
            r_rdata_q      <= '0;
            r_is_read_q    <= 1'b0;
            r_mem_rd_valid <= 1'b0;
            r_mem_wr_valid <= 1'b0;
            r_resp_ready   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A memory ready still high from the last op would complete a new one instantly.
                    if (w_found && !mem_read_ready && !mem_write_ready) begin
                        r_grant     <= w_idx;
                        r_is_read_q <= req_read_valid[w_idx];
                        if (req_read_valid[w_idx]) begin
                            r_addr_q       <= req_read_address[w_idx];
                            r_mem_rd_valid <= 1'b1;
                            r_state        <= READ_WAIT;
                        end else begin
                            r_addr_q       <= req_write_address[w_idx];
                            r_wdata_q      <= req_write_data[w_idx];
                            r_mem_wr_valid <= 1'b1;
                            r_state        <= WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready) begin
                        r_rdata_q      <= mem_read_data;
                        r_mem_rd_valid <= 1'b0;
                        r_resp_ready   <= 1'b1;
                        r_state        <= RESPOND;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready) begin
                        r_mem_wr_valid <= 1'b0;
                        r_resp_ready   <= 1'b1;
                        r_state        <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (!w_granted_valid) begin
                        r_resp_ready <= 1'b0;
                        r_rdata_q    <= '0;
                        r_last_grant <= r_grant;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Only the granted channel ever sees ready or data; all others read back zero.
    always_comb begin
        req_read_ready  = '0;
        req_write_ready = '0;
        req_read_data   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_resp_ready && (r_grant == GW'(i))) begin
                req_read_ready[i]  = r_is_read_q;
                req_write_ready[i] = !r_is_read_q;
                req_read_data[i]   = r_is_read_q ? r_rdata_q : '0;
            end
        end
    end

    assign mem_read_valid    = r_mem_rd_valid;
    assign mem_read_address  = r_addr_q;
    assign mem_write_valid   = r_mem_wr_valid;
    assign mem_write_address = r_addr_q;
    assign mem_write_data    = r_wdata_q;
    assign grant             = r_grant;
    assign busy              = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: responses are matched in order against expected transactions.
module tb_mem_port_arbiter;

    localparam int CH = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [CH-1:0]        req_read_valid, req_read_ready;
    logic [CH-1:0]        req_write_valid, req_write_ready;
    logic [CH-1:0][AW-1:0] req_read_address, req_write_address;
    logic [CH-1:0][DW-1:0] req_read_data, req_write_data;
    logic                 mem_read_valid, mem_read_ready;
    logic                 mem_write_valid, mem_write_ready;
    logic [AW-1:0]        mem_read_address, mem_write_address;
    logic [DW-1:0]        mem_read_data, mem_write_data;
    logic [1:0]           grant;
    logic                 busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_BITS (AW),
        .DATA_BITS (DW),
        .CHANNELS  (CH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_read_valid    (req_read_valid),
        .req_read_address  (req_read_address),
        .req_read_ready    (req_read_ready),
        .req_read_data     (req_read_data),
        .req_write_valid   (req_write_valid),
        .req_write_address (req_write_address),
        .req_write_data    (req_write_data),
        .req_write_ready   (req_write_ready),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_ready   (mem_write_ready),
        .grant             (grant),
        .busy              (busy)
    );

    typedef struct {
        int         ch;
        bit         is_read;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] mem_arr [256];
    bit         mem_auto;
    int         mem_lat;
    int         rd_wait, wr_wait;
    logic [7:0] last_rd_addr, last_wr_addr, last_wr_data;

    function automatic logic [7:0] pat(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    task automatic expect_txn(input int ch, input bit rd, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.ch = ch; e.is_read = rd; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Memory model: answers each mem valid after mem_lat cycles with a one-cycle ready pulse.
    initial begin
        mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
        rd_wait = 0; wr_wait = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_auto) begin
                if (mem_read_ready) begin
                    mem_read_ready = 1'b0; mem_read_data = '0;
                end else if (mem_read_valid) begin
                    rd_wait++;
                    if (rd_wait >= mem_lat) begin
                        mem_read_ready = 1'b1; mem_read_data = mem_arr[mem_read_address]; rd_wait = 0;
                    end
                end else rd_wait = 0;
                if (mem_write_ready) begin
                    mem_write_ready = 1'b0;
                end else if (mem_write_valid) begin
                    wr_wait++;
                    if (wr_wait >= mem_lat) begin
                        mem_write_ready = 1'b1; mem_arr[mem_write_address] = mem_write_data; wr_wait = 0;
                    end
                end else wr_wait = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each requester ready rising edge and checks invariants.
    logic [CH-1:0] prev_rr = '0, prev_wr = '0, rise_r, rise_w;
    exp_t          mon_e;
    int            mon_ch;
    bit            mon_rd;
    logic [7:0]    mon_addr, mon_data;
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (mem_read_valid && mem_read_ready) last_rd_addr = mem_read_address;
            if (mem_write_valid && mem_write_ready) begin
                last_wr_addr = mem_write_address; last_wr_data = mem_write_data;
            end
            vectors++;
            if ($countones({req_read_ready, req_write_ready}) > 1) begin
                miscompares++;
                $display("FAIL one_ready: rd_ready=%b wr_ready=%b, want at most one bit", req_read_ready, req_write_ready);
            end
            for (int c = 0; c < CH; c++) begin
                if (!req_read_ready[c] && req_read_data[c] !== '0) begin
                    miscompares++;
                    $display("FAIL idle_data ch%0d: got %h want 00", c, req_read_data[c]);
                end
            end
            rise_r = req_read_ready & ~prev_rr;
            rise_w = req_write_ready & ~prev_wr;
            if (rise_r != '0 || rise_w != '0) begin
                mon_ch = -1; mon_rd = 1'b0;
                for (int c = 0; c < CH; c++) begin
                    if (rise_r[c] || rise_w[c]) begin mon_ch = c; mon_rd = rise_r[c]; end
                end
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_resp: ch%0d read=%0d, want no response", mon_ch, mon_rd);
                end else begin
                    mon_e    = exp_q.pop_front();
                    mon_addr = mon_rd ? last_rd_addr : last_wr_addr;
                    mon_data = mon_rd ? req_read_data[mon_ch] : last_wr_data;
                    if (mon_ch !== mon_e.ch || mon_rd !== mon_e.is_read ||
                        mon_addr !== mon_e.addr || mon_data !== mon_e.data) begin
                        miscompares++;
                        $display("FAIL resp: got ch%0d rd=%0d addr=%h data=%h, want ch%0d rd=%0d addr=%h data=%h",
                                 mon_ch, mon_rd, mon_addr, mon_data, mon_e.ch, mon_e.is_read, mon_e.addr, mon_e.data);
                    end
                end
            end
        end
        prev_rr = req_read_ready;
        prev_wr = req_write_ready;
    end

    task automatic clear_requests();
        req_read_valid = '0; req_write_valid = '0;
        req_read_address = '0; req_write_address = '0; req_write_data = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_requests();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Completes outstanding requests, dropping each valid as soon as its ready is seen.
    task automatic serve(input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
            @(negedge clk); n++;
            for (int c = 0; c < CH; c++) begin
                if (req_read_ready[c])  req_read_valid[c]  = 1'b0;
                if (req_write_ready[c]) req_write_valid[c] = 1'b0;
            end
        end
        vectors++;
        if (exp_q.size() != 0 || busy) begin
            miscompares++;
            $display("FAIL serve_timeout: %0d responses outstanding busy=%0d, want 0/0", exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_requests();
        @(negedge clk);
        vectors++;
        if (busy !== 0 || grant !== 0 || mem_read_valid !== 0 || mem_write_valid !== 0 ||
            mem_read_address !== 0 || mem_write_address !== 0 || mem_write_data !== 0 ||
            req_read_ready !== 0 || req_write_ready !== 0 || req_read_data !== 0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%0d grant=%0d mrv=%0d mwv=%0d rr=%b wr=%b, want all 0",
                     busy, grant, mem_read_valid, mem_write_valid, req_read_ready, req_write_ready);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 0 || mem_read_valid !== 0 || mem_write_valid !== 0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%0d mrv=%0d mwv=%0d, want 0", busy, mem_read_valid, mem_write_valid);
        end
    endtask

    task automatic test_single_read();
        int n;
        mem_lat = 3;
        mem_arr[8'h10] = 8'hA5;
        @(negedge clk);
        req_read_address[2] = 8'h10; req_read_valid[2] = 1'b1;
        expect_txn(2, 1'b1, 8'h10, 8'hA5);
        @(negedge clk);
        vectors++;
        if (mem_read_valid !== 1 || mem_read_address !== 8'h10 || grant !== 2 || busy !== 1) begin
            miscompares++;
            $display("FAIL read_issue: mrv=%0d addr=%h grant=%0d busy=%0d, want 1/10/2/1",
                     mem_read_valid, mem_read_address, grant, busy);
        end
        n = 0;
        while (!mem_read_ready && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (n >= 20 || req_read_ready !== 0 || mem_read_valid !== 1 || mem_read_address !== 8'h10) begin
            miscompares++;
            $display("FAIL read_wait: n=%0d rr=%b mrv=%0d addr=%h, want rr=0000 mrv=1 addr=10",
                     n, req_read_ready, mem_read_valid, mem_read_address);
        end
        @(negedge clk);
        vectors++;
        if (req_read_ready !== 4'b0100 || req_read_data[2] !== 8'hA5 || mem_read_valid !== 0) begin
            miscompares++;
            $display("FAIL read_resp: rr=%b data=%h mrv=%0d, want 0100/a5/0", req_read_ready, req_read_data[2], mem_read_valid);
        end
        req_read_valid[2] = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_read_ready !== 0 || req_read_data !== 0 || busy !== 0) begin
            miscompares++;
            $display("FAIL read_release: rr=%b busy=%0d, want 0000/0", req_read_ready, busy);
        end
    endtask

    task automatic test_round_robin();
        int   left[CH];
        int   n, pending;
        logic [7:0] a;
        apply_reset();
        mem_lat = 1;
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            a = 8'(8'h80 + c * 16);
            req_read_address[c] = a; req_read_valid[c] = 1'b1;
            expect_txn(c, 1'b1, a, pat(a));
            left[c] = 1;
        end
        n = 0;
        do begin
            @(negedge clk); n++;
            pending = 0;
            for (int c = 0; c < CH; c++) begin
                if (req_read_valid[c] && req_read_ready[c]) begin
                    req_read_valid[c] = 1'b0;
                end else if (!req_read_valid[c] && left[c] > 0) begin
                    a = 8'(8'h81 + c * 16);
                    req_read_address[c] = a; req_read_valid[c] = 1'b1;
                    expect_txn(c, 1'b1, a, pat(a));
                    left[c]--;
                end
                pending += left[c] + int'(req_read_valid[c]);
            end
        end while ((pending != 0 || busy) && n < 400);
        vectors++;
        if (pending != 0 || busy) begin
            miscompares++;
            $display("FAIL rr_timeout: pending=%0d busy=%0d, want 0/0", pending, busy);
        end
    endtask

    task automatic test_read_before_write();
        int n;
        mem_lat = 2;
        @(negedge clk);
        req_read_address[1] = 8'h20; req_write_address[1] = 8'h30; req_write_data[1] = 8'h7E;
        req_read_valid[1] = 1'b1; req_write_valid[1] = 1'b1;
        expect_txn(1, 1'b1, 8'h20, pat(8'h20));
        expect_txn(1, 1'b0, 8'h30, 8'h7E);
        @(negedge clk);
        vectors++;
        if (mem_read_valid !== 1 || mem_write_valid !== 0 || mem_read_address !== 8'h20 || grant !== 1) begin
            miscompares++;
            $display("FAIL rw_priority: mrv=%0d mwv=%0d addr=%h grant=%0d, want 1/0/20/1",
                     mem_read_valid, mem_write_valid, mem_read_address, grant);
        end
        n = 0;
        while (!req_read_ready[1] && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (req_read_ready !== 4'b0010 || req_write_ready !== 0 || mem_write_valid !== 0) begin
            miscompares++;
            $display("FAIL rw_read_done: rr=%b wr=%b mwv=%0d, want 0010/0000/0", req_read_ready, req_write_ready, mem_write_valid);
        end
        @(negedge clk);
        vectors++;
        if (req_read_ready !== 4'b0010 || req_read_data[1] !== pat(8'h20)) begin
            miscompares++;
            $display("FAIL rw_ready_hold: rr=%b data=%h, want 0010/%h", req_read_ready, req_read_data[1], pat(8'h20));
        end
        req_read_valid[1] = 1'b0;
        serve(60);
        vectors++;
        if (mem_arr[8'h30] !== 8'h7E) begin
            miscompares++;
            $display("FAIL rw_mem_write: mem[30]=%h, want 7e", mem_arr[8'h30]);
        end
    endtask

    task automatic test_write_drop_valid();
        int n;
        mem_lat = 2;
        @(negedge clk);
        req_write_address[0] = 8'h55; req_write_data[0] = 8'h3C; req_write_valid[0] = 1'b1;
        expect_txn(0, 1'b0, 8'h55, 8'h3C);
        @(negedge clk);
        vectors++;
        if (mem_write_valid !== 1 || mem_write_address !== 8'h55 || mem_write_data !== 8'h3C || grant !== 0) begin
            miscompares++;
            $display("FAIL wr_issue: mwv=%0d addr=%h data=%h grant=%0d, want 1/55/3c/0",
                     mem_write_valid, mem_write_address, mem_write_data, grant);
        end
        req_write_valid[0] = 1'b0;
        n = 0;
        while (!req_write_ready[0] && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (req_write_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL wr_committed: wr=%b after %0d cycles, want 0001", req_write_ready, n);
        end
        @(negedge clk);
        vectors++;
        if (req_write_ready !== 0 || busy !== 0 || mem_arr[8'h55] !== 8'h3C) begin
            miscompares++;
            $display("FAIL wr_pulse: wr=%b busy=%0d mem[55]=%h, want 0000/0/3c", req_write_ready, busy, mem_arr[8'h55]);
        end
    endtask

    task automatic test_reset_mid_read();
        mem_lat = 10;
        @(negedge clk);
        req_read_address[3] = 8'h33; req_read_valid[3] = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_read_valid !== 1 || grant !== 3) begin
            miscompares++;
            $display("FAIL mid_issue: mrv=%0d grant=%0d, want 1/3", mem_read_valid, grant);
        end
        @(negedge clk);
        reset_n = 1'b0;
        req_read_valid[3] = 1'b0;
        #1;
        vectors++;
        if (busy !== 0 || grant !== 0 || mem_read_valid !== 0 || mem_read_address !== 0 ||
            req_read_ready !== 0 || req_write_ready !== 0) begin
            miscompares++;
            $display("FAIL async_reset: busy=%0d grant=%0d mrv=%0d addr=%h, want all 0",
                     busy, grant, mem_read_valid, mem_read_address);
        end
        @(negedge clk);
        reset_n = 1'b1;
        mem_lat = 1;
        @(negedge clk);
        req_read_address[0] = 8'h44; req_read_address[2] = 8'h48;
        req_read_valid[0] = 1'b1; req_read_valid[2] = 1'b1;
        expect_txn(0, 1'b1, 8'h44, pat(8'h44));
        expect_txn(2, 1'b1, 8'h48, pat(8'h48));
        @(negedge clk);
        vectors++;
        if (grant !== 0 || mem_read_valid !== 1 || mem_read_address !== 8'h44) begin
            miscompares++;
            $display("FAIL post_reset_grant: grant=%0d mrv=%0d addr=%h, want 0/1/44", grant, mem_read_valid, mem_read_address);
        end
        serve(60);
    endtask

    task automatic test_ready_held();
        mem_auto = 1'b0;
        @(negedge clk);
        req_read_address[2] = 8'h66; req_read_valid[2] = 1'b1;
        expect_txn(2, 1'b1, 8'h66, pat(8'h66));
        @(posedge clk); #1;
        mem_read_ready = 1'b1; mem_read_data = pat(8'h66);
        req_read_address[1] = 8'h77; req_read_valid[1] = 1'b1;
        expect_txn(1, 1'b1, 8'h77, pat(8'h77));
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (req_read_ready !== 4'b0100 || req_read_data[1] !== 0 || req_read_data[0] !== 0 || req_read_data[3] !== 0) begin
            miscompares++;
            $display("FAIL held_resp: rr=%b data=%h, want 0100 with other channels 00", req_read_ready, req_read_data);
        end
        req_read_valid[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (mem_read_valid !== 0 || busy !== 0 || req_read_data !== 0) begin
                miscompares++;
                $display("FAIL held_no_issue cyc%0d: mrv=%0d busy=%0d data=%h, want 0/0/0", i, mem_read_valid, busy, req_read_data);
            end
        end
        mem_read_ready = 1'b0; mem_read_data = '0;
        @(negedge clk);
        vectors++;
        if (mem_read_valid !== 1 || grant !== 1 || mem_read_address !== 8'h77) begin
            miscompares++;
            $display("FAIL held_release: mrv=%0d grant=%0d addr=%h, want 1/1/77", mem_read_valid, grant, mem_read_address);
        end
        mem_lat = 2;
        mem_auto = 1'b1;
        serve(60);
    endtask

    initial begin
        reset_n = 1'b0;
        clear_requests();
        mem_auto = 1'b1;
        mem_lat = 1;
        for (int a = 0; a < 256; a++) mem_arr[a] = pat(8'(a));
        test_reset();
        test_single_read();
        test_round_robin();
        test_read_before_write();
        test_write_drop_valid();
        test_reset_mid_read();
        test_ready_held();
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
